// File: rtl/seq_burst_arbiter.sv
// Round-robin arbiter granting bursts of a shared sequence generator to NREQ requesters.
// Grant/gen_en follow the arbitration cycle by one; out_valid trails gen_en by one cycle.
module seq_burst_arbiter #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 4,
  parameter int DW    = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       grant,
  output logic                  gen_en,
  input  logic [DW-1:0]         gen_data,
  output logic [DW-1:0]         out_data,
  output logic                  out_valid,
  output logic [IDW-1:0]        out_id,
  output logic                  done,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   out_id_q, out_id_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic             gen_en_q, gen_en_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             sel_vld;
  logic [IDW-1:0]   sel_idx;
  logic [IDW-1:0]   cand;
  logic [LEN_W-1:0] sel_len;

  // Search upward from ptr+1 so the last-served requester has lowest priority.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    sel_len = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      if (!sel_vld && req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == IDW'(i)) sel_len = req_len[i*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    gen_en_d    = 1'b0;
    done_d      = 1'b0;
    out_valid_d = gen_en_q;
    out_id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          grant_d = NREQ'(1) << sel_idx;
          id_d    = sel_idx;
          ptr_d   = sel_idx;
          cnt_d   = sel_len;
          busy_d  = 1'b1;
          if (sel_len == '0) begin
            state_d = DRAIN;
            done_d  = 1'b1;
          end else begin
            state_d  = RUN;
            gen_en_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt_q == LEN_W'(1)) begin
          state_d = DRAIN;
          done_d  = 1'b1;
        end else begin
          cnt_d    = cnt_q - LEN_W'(1);
          gen_en_d = 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      id_q        <= '0;
      out_id_q    <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      gen_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      out_id_q    <= out_id_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      gen_en_q    <= gen_en_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign gen_en    = gen_en_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign done      = done_q;
  assign busy      = busy_q;
  // gen_data is already the generator's registered result, aligned with out_valid.
  assign out_data  = out_valid_q ? gen_data : '0;

endmodule
